clock_setup_ctrl: RTL

//  Upstream control stage for the hour/minute/second counter chain. Turns three raw push-buttons
//  (mode, up, down) into the counters' setup_imp/setup_data load strobes and the run enable that

---
 rtl/clock_setup_ctrl_pkg.sv | 20 ++
 rtl/clock_setup_ctrl_if.sv | 24 ++
 rtl/clock_setup_ctrl_btn_debounce.sv | 47 ++++
 rtl/clock_setup_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/clock_setup_ctrl_pkg.sv
// clock_setup_ctrl_pkg: edit states, field indices, limits and step arithmetic for the clock setup controller.
package clock_setup_ctrl_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} edit_state_t;

  localparam int FIELD_HOUR = 2;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_SEC  = 0;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  // Out-of-range values snap to 0 going up and to the limit going down.
  function automatic logic [7:0] step_value(input logic [7:0] cur, input logic [7:0] lim, input logic up);
    return up ? ((cur >= lim) ? 8'd0 : cur + 8'd1)
              : ((cur == 8'd0 || cur > lim) ? lim : cur - 8'd1);
  endfunction

endpackage

// File: rtl/clock_setup_ctrl_if.sv
// clock_setup_ctrl_if: buttons, counter values and setup/display outputs of the clock setup controller.
interface clock_setup_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic       run_en;
  logic [2:0] setup_imp;
  logic [7:0] setup_data;
  logic [1:0] field_sel;
  logic       blink;

  modport master (
    output btn_mode, btn_up, btn_down, cur_hour, cur_min, cur_sec,
    input  run_en, setup_imp, setup_data, field_sel, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_hour, cur_min, cur_sec,
    output run_en, setup_imp, setup_data, field_sel, blink
  );
endinterface

// File: rtl/clock_setup_ctrl_btn_debounce.sv
// clock_setup_ctrl_btn_debounce: 2-FF sync, debounce, press pulse and optional hold-to-repeat steps.
module clock_setup_ctrl_btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic        s0, s1, level, first;
  logic [31:0] cnt, rcnt;
  logic        accept, rise, rep_hit;

  always_comb begin
    accept  = (s1 != level) && (cnt == 32'(DEBOUNCE_CYC - 1));
    rise    = accept && s1;
    rep_hit = REPEAT_EN && level && !accept &&
              (rcnt + 32'd1 == 32'(first ? REPEAT_DLY : REPEAT_PER));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rcnt  <= '0;
      first <= 1'b1;
      pulse <= 1'b0;
    end else begin
      s0    <= raw;
      s1    <= s0;
      cnt   <= (s1 == level || accept) ? '0 : cnt + 32'd1;
      level <= accept ? s1 : level;
      pulse <= rise || rep_hit;
      rcnt  <= (!level || rep_hit) ? '0 : rcnt + 32'd1;
      first <= !level ? 1'b1 : (rep_hit ? 1'b0 : first);
    end
  end

  always_ff @(posedge clock) assert (DEBOUNCE_CYC >= 2 && REPEAT_PER >= 2);

endmodule

// File: rtl/clock_setup_ctrl.sv
// clock_setup_ctrl: button-driven edit FSM producing counter load strobes, run enable and display blink.
module clock_setup_ctrl
  import clock_setup_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter int         REPEAT_DLY   = 25_000_000,
  parameter int         REPEAT_PER   = 5_000_000,
  parameter int         BLINK_HALF   = 12_500_000,
  parameter logic [7:0] HOUR_LIMIT   = HOUR_MAX,
  parameter logic [7:0] MIN_LIMIT    = MIN_MAX,
  parameter logic [7:0] SEC_LIMIT    = SEC_MAX
) (
  input logic               clock,
  input logic               reset,
  clock_setup_ctrl_if.slave bus
);

  logic        mode_p, up_s, down_s;
  edit_state_t state, nxt;
  logic [7:0]  cur, lim;
  logic [2:0]  hot;
  logic [31:0] bcnt;

  clock_setup_ctrl_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0)
  ) u_mode (.clock(clock), .reset(reset), .raw(bus.btn_mode), .pulse(mode_p));

  clock_setup_ctrl_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1)
  ) u_up (.clock(clock), .reset(reset), .raw(bus.btn_up), .pulse(up_s));

  clock_setup_ctrl_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1)
  ) u_down (.clock(clock), .reset(reset), .raw(bus.btn_down), .pulse(down_s));

  always_comb begin
    nxt = edit_state_t'(state + 2'd1);
    cur = (state == SET_H) ? bus.cur_hour : (state == SET_M) ? bus.cur_min : bus.cur_sec;
    lim = (state == SET_H) ? HOUR_LIMIT : (state == SET_M) ? MIN_LIMIT : SEC_LIMIT;
    hot = (state == SET_H) ? 3'(1 << FIELD_HOUR) : (state == SET_M) ? 3'(1 << FIELD_MIN) : 3'(1 << FIELD_SEC);
  end

  // A mode press takes priority: the state advances and any same-cycle step is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      bus.run_en     <= 1'b1;
      bus.setup_imp  <= '0;
      bus.setup_data <= '0;
      bus.field_sel  <= '0;
      bus.blink      <= 1'b0;
      bcnt           <= '0;
    end else begin
      bus.setup_imp <= '0;
      if (mode_p) begin
        state         <= nxt;
        bus.run_en    <= (nxt == RUN);
        bus.field_sel <= nxt;
        bus.blink     <= 1'b0;
        bcnt          <= '0;
      end else if (state != RUN) begin
        if (up_s ^ down_s) begin
          bus.setup_imp  <= hot;
          bus.setup_data <= step_value(cur, lim, up_s);
        end
        bcnt      <= (bcnt == 32'(BLINK_HALF - 1)) ? '0 : bcnt + 32'd1;
        bus.blink <= (bcnt == 32'(BLINK_HALF - 1)) ? ~bus.blink : bus.blink;
      end
    end
  end

endmodule
